// File: rtl/alu_pkg.sv
// Shared constants for the ALU operation sequencer: widths, flag bit positions and select codes.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int SEL_W   = 4;
  localparam int MAX_SEL = 12;
  localparam int FLAG_W  = 4;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;

  localparam logic [SEL_W-1:0] SEL_ADD  = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_SUB  = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_MUL  = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_DIV  = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_SHL  = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_SHR  = 4'b0101;
  localparam logic [SEL_W-1:0] SEL_ROL  = 4'b0110;
  localparam logic [SEL_W-1:0] SEL_ROR  = 4'b0111;
  localparam logic [SEL_W-1:0] SEL_AND  = 4'b1000;
  localparam logic [SEL_W-1:0] SEL_OR   = 4'b1001;
  localparam logic [SEL_W-1:0] SEL_XOR  = 4'b1010;
  localparam logic [SEL_W-1:0] SEL_NOR  = 4'b1011;
  localparam logic [SEL_W-1:0] SEL_NAND = 4'b1100;

  function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
    return sel <= SEL_W'(MAX_SEL);
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Generic synchronous FIFO holding ALU requests; exposes the head entry combinationally
// from storage along with occupancy, empty and full.
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [WIDTH-1:0]          i_wdata,
  output logic [WIDTH-1:0]          o_head,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_empty,
  output logic                      o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A pop frees the head slot in the same cycle, so a push is allowed even when full.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/alu_op_sequencer.sv
// Request FIFO and one-entry result capture stage wrapped around an external combinational ALU.
// Optional ALU_SEQ_ILLEGAL_TRAP_EN: out-of-range select codes bypass the ALU and return a zero result flagged by illegal_op.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int SEL_W   = alu_pkg::SEL_W,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_neg,
  input  logic                     alu_carry,
  input  logic                     alu_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [3:0]               out_flags,
  output logic [SEL_W-1:0]         out_sel,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic                     illegal_op
`endif
);

  localparam int REQ_W = 2 * DATA_W + SEL_W;

  logic [REQ_W-1:0]  w_wdata;
  logic [REQ_W-1:0]  w_head;
  logic [DATA_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_b;
  logic [SEL_W-1:0]  w_head_sel;
  logic              w_push;
  logic              w_capture;
  logic              w_empty;
  logic              w_full;
  logic              w_drive_en;
  logic [3:0]        w_alu_flags;
  logic [DATA_W-1:0] w_cap_result;
  logic [3:0]        w_cap_flags;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic [3:0]        r_out_flags;
  logic [SEL_W-1:0]  r_out_sel;

  // Ready comes only from registered occupancy, never from out_ready.
  assign in_ready  = !rst && !w_full;
  assign w_push    = in_valid && in_ready;
  assign w_wdata   = {in_a, in_b, in_sel};
  assign w_capture = !w_empty && (!r_out_valid || out_ready);

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_capture),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (fifo_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign {w_head_a, w_head_b, w_head_sel} = w_head;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic w_head_illegal;
  logic r_illegal;

  assign w_head_illegal = !w_empty && !sel_is_legal(w_head_sel);
  assign w_drive_en     = !w_empty && !w_head_illegal;
  assign illegal_op     = r_illegal;
`else
  assign w_drive_en     = !w_empty;
`endif

  assign alu_a   = w_drive_en ? w_head_a   : '0;
  assign alu_b   = w_drive_en ? w_head_b   : '0;
  assign alu_sel = w_drive_en ? w_head_sel : '0;

  always_comb begin
    w_alu_flags             = '0;
    w_alu_flags[FLAG_ZERO]  = alu_zero;
    w_alu_flags[FLAG_NEG]   = alu_neg;
    w_alu_flags[FLAG_CARRY] = alu_carry;
    w_alu_flags[FLAG_OVF]   = alu_ovf;
  end

  always_comb begin
    w_cap_result = alu_result;
    w_cap_flags  = w_alu_flags;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    if (w_head_illegal) begin
      w_cap_result = '0;
      w_cap_flags  = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
      r_out_sel    <= '0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_cap_result;
      r_out_flags  <= w_cap_flags;
      r_out_sel    <= w_head_sel;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_capture) begin
      r_illegal <= w_head_illegal;
    end
  end
`endif

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;
  assign out_sel    = r_out_sel;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: ALU stub, transaction-level scoreboard queue and directed plus random steps.
// Honours ALU_SEQ_ILLEGAL_TRAP_EN when the design is built with it.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_neg;
  logic       alu_carry;
  logic       alu_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [3:0] out_sel;
  logic [2:0] fifo_count;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_sel    (out_sel),
    .fifo_count (fifo_count)
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  // Returns {ovf, carry, neg, zero, result[7:0]}.
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    logic       v;
    w = '0;
    c = 1'b0;
    v = 1'b0;
    case (sel)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[7:0];
        c = w[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'd8:    r = a & b;
      4'd9:    r = a | b;
      4'd10:   r = a ^ b;
      default: r = a ^ {b[3:0], sel};
    endcase
    return {v, c, r[7], (r == 8'h00), r};
  endfunction

  always_comb begin
    {alu_ovf, alu_carry, alu_neg, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_sel);
  end

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    logic [3:0] sel;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    exp_t       e;
    logic [11:0] f;
    f     = alu_fn(a, b, sel);
    e.res = f[7:0];
    e.flg = f[11:8];
    e.sel = sel;
    e.ill = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    if (sel > 4'd12) begin
      e.res = 8'h00;
      e.flg = 4'h0;
      e.ill = 1'b1;
    end
`endif
    return e;
  endfunction

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic last_fi = 1'b0;
  logic last_fo = 1'b0;
  int   n_out;
  int   first_out;
  int   last_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: note handshakes before the edge, then score them against the model after it.
  task automatic tick();
    logic       fi;
    logic       fo;
    logic       rs;
    logic [7:0] o_r;
    logic [3:0] o_f;
    logic [3:0] o_s;
    logic       o_i;
    exp_t       ne;
    exp_t       e;
    fi  = in_valid && in_ready;
    fo  = out_valid && out_ready;
    rs  = rst;
    o_r = out_result;
    o_f = out_flags;
    o_s = out_sel;
    o_i = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    o_i = illegal_op;
`endif
    ne = model(in_a, in_b, in_sel);
    @(posedge clk);
    #1;
    cyc++;
    last_fi = (fi === 1'b1);
    last_fo = (fo === 1'b1);
    if (rs === 1'b1) begin
      exp_q.delete();
    end else begin
      if (last_fo) begin
        check("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_result", 32'(o_r), 32'(e.res));
          check("sb_flags", 32'(o_f), 32'(e.flg));
          check("sb_sel", 32'(o_s), 32'(e.sel));
          check("sb_illegal", 32'(o_i), 32'(e.ill));
        end
      end
      if (last_fi) exp_q.push_back(ne);
    end
    check("occupancy", 32'(fifo_count) + 32'(out_valid), 32'(exp_q.size()));
  endtask

  task automatic note_out();
    if (last_fo) begin
      if (n_out == 0) first_out = cyc;
      last_out = cyc;
      n_out++;
    end
  endtask

  task automatic rand_req(input logic legal_only);
    in_a   = 8'($urandom);
    in_b   = 8'($urandom);
    in_sel = legal_only ? 4'($urandom_range(0, 12)) : 4'($urandom_range(0, 15));
  endtask

  initial begin
    int maxc;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sel    = '0;
    out_ready = 1'b0;
    rst       = 1'b1;

    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_fifo_count", 32'(fifo_count), 32'd0);
    check("idle_alu_a", 32'(alu_a), 32'd0);
    check("idle_alu_b", 32'(alu_b), 32'd0);
    check("idle_alu_sel", 32'(alu_sel), 32'd0);

    // Single op, latency N+2
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'hCA;
    in_b      = 8'h67;
    in_sel    = 4'b0000;
    tick();
    in_valid = 1'b0;
    check("single_accept", 32'(last_fi), 32'd1);
    check("single_n1_valid", 32'(out_valid), 32'd0);
    check("single_alu_a", 32'(alu_a), 32'hCA);
    check("single_alu_b", 32'(alu_b), 32'h67);
    check("single_alu_sel", 32'(alu_sel), 32'd0);
    tick();
    check("single_n2_valid", 32'(out_valid), 32'd1);
    check("single_result", 32'(out_result), 32'h31);
    check("single_flags", 32'(out_flags), 32'b0100);
    tick();
    check("single_consumed", 32'(last_fo), 32'd1);
    check("single_after_valid", 32'(out_valid), 32'd0);

    // Back-pressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      rand_req(1'b1);
      tick();
      check("bp_accept", 32'(last_fi), 32'd1);
    end
    rand_req(1'b1);
    check("bp_fifo_count", 32'(fifo_count), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_held", 32'(last_fi), 32'd0);
    check("bp_held_valid", 32'(out_valid), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_out = 0;
    first_out = 0;
    last_out = 0;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
      tick();
      note_out();
    end
    check("bp_drain_count", 32'(n_out), 32'd5);
    check("bp_drain_span", 32'(last_out - first_out), 32'd4);

    // Streaming
    n_out = 0;
    first_out = 0;
    last_out = 0;
    maxc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      rand_req(1'b1);
      tick();
      check("stream_accept", 32'(last_fi), 32'd1);
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      note_out();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      tick();
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      note_out();
    end
    check("stream_count", 32'(n_out), 32'd16);
    check("stream_span", 32'(last_out - first_out), 32'd15);
    check("stream_max_fifo", 32'(maxc), 32'd1);

    // Reset with work in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      rand_req(1'b1);
      tick();
    end
    in_valid = 1'b0;
    check("mid_fifo_count", 32'(fifo_count), 32'd3);
    check("mid_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    // Illegal select between two legal ops
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = 8'h12; in_b = 8'h34; in_sel = 4'b0000;
    tick();
    in_a = 8'h55; in_b = 8'h66; in_sel = 4'b1110;
    tick();
    in_a = 8'h40; in_b = 8'h01; in_sel = 4'b0001;
    tick();
    in_valid = 1'b0;
    check("trap_sel", 32'(out_sel), 32'hE);
    check("trap_result", 32'(out_result), 32'd0);
    check("trap_flags", 32'(out_flags), 32'd0);
    check("trap_illegal", 32'(illegal_op), 32'd1);
    tick();
    check("trap_next_result", 32'(out_result), 32'h3F);
    check("trap_next_illegal", 32'(illegal_op), 32'd0);
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) tick();
`endif

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rand_req(1'b0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream issue stage and downstream capture stage wrapped around the combinational 8-bit ALU (ALU_8_bit).
- Accepts operation requests (a, b, select_line) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the FIFO head onto the ALU inputs.
- Registers the ALU result and flags into a one-entry output stage with its own valid/ready handshake.
- Decouples ALU operand producers from result consumers and gives a registered, back-pressurable ALU path.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- SEL_W, 4, select_line width.
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- MAX_SEL, 12, highest legal select code (4'b1100).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- in_a  in  DATA_W  operand a.
- in_b  in  DATA_W  operand b.
- in_sel  in  SEL_W  operation select.
- alu_a  out  DATA_W  to ALU a (FIFO head a, 0 when FIFO empty).
- alu_b  out  DATA_W  to ALU b (FIFO head b, 0 when empty).
- alu_sel  out  SEL_W  to ALU select_line (head sel, 0 when empty).
- alu_result  in  DATA_W  from ALU.
- alu_zero  in  1  from ALU.
- alu_neg  in  1  from ALU.
- alu_carry  in  1  from ALU.
- alu_ovf  in  1  from ALU.
- out_valid  out  1  captured result valid.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- out_result  out  DATA_W  captured result.
- out_flags  out  4  {ovf,carry,neg,zero} captured.
- out_sel  out  SEL_W  select code of the captured op.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - FIFO read/write pointers and fifo_count cleared to 0.
  - out_valid, out_result, out_flags and out_sel cleared to 0.
  - in_ready=0 while rst is high.
  - Reset mid-operation discards all buffered and captured ops; no partial output is produced.
- Request FIFO:
  - in_ready = (fifo_count < DEPTH). It depends only on registered state, with no combinational path from out_ready.
  - Push on in_valid&&in_ready.
  - Pop when the head is captured (see below).
  - Push and pop in the same cycle leave the count unchanged, including when the FIFO is full. in_ready is still 0 when full, so this case only arises below DEPTH.
  - Pointers wrap modulo DEPTH.
- ALU drive: alu_a/alu_b/alu_sel come from the FIFO head and are combinational from registered storage. When the FIFO is empty they are forced to 0.
- Capture: capture = (fifo_count≠0) && (!out_valid || out_ready). On capture:
  - out_result ← alu_result.
  - out_flags ← {alu_ovf,alu_carry,alu_neg,alu_zero}.
  - out_sel ← head sel.
  - out_valid ← 1.
  - The head is popped.
- If out_valid && out_ready && no capture, then out_valid ← 0.
- Output registers hold stable while out_valid && !out_ready.
- Latency: request accepted at edge N → ALU sees it in cycle N+1 → out_valid=1 in cycle N+2. This assumes an empty FIFO and an idle or ready output.
- Throughput: 1 op/cycle sustained when out_ready=1.
- Ordering: results leave strictly in request order; no op is dropped or duplicated.
- Select codes above MAX_SEL pass through unchanged; the result is whatever the ALU produces.

Optional Feature:
ALU_SEQ_ILLEGAL_TRAP_EN
- Defined:
  - A request with in_sel > MAX_SEL is still accepted but never reaches the ALU.
  - At capture it produces out_result=0 and out_flags=4'b0000, with out_sel preserved.
  - An extra output port illegal_op (1 bit) is registered alongside out_valid and is high for exactly that result.
  - Order and latency are unchanged.
- Undefined: no illegal_op port; illegal codes pass through as above.

Decomposition:
- Shared package alu_pkg:
  - DATA_W, SEL_W and MAX_SEL constants.
  - Flag bit index constants: FLAG_ZERO=0, FLAG_NEG=1, FLAG_CARRY=2, FLAG_OVF=3.
  - Named select-code constants for 0000–1100.
- One sub-module: alu_req_fifo. It is a generic synchronous FIFO (DEPTH, width = 2*DATA_W+SEL_W) with push/pop/count/head outputs. The capture register stays in the top.

Test Plan:
Bench uses an ALU stub computing sel 0000 as add: result=(a+b)[7:0], carry=bit8, zero/neg from result, ovf signed.
- Reset then idle → out_valid=0, fifo_count=0, alu_a/alu_b/alu_sel=0, in_ready=1 one cycle after rst deasserts.
- Single op a=8'hCA b=8'h67 sel=0000 at edge N, out_ready=1 → out_valid in cycle N+2 with out_result=8'h31, out_flags=4'b0100 (carry only).
- Back-pressure: out_ready=0, push 5 ops → 1 captured plus 4 buffered, fifo_count=4, in_ready=0. The 6th request is held. Release out_ready → all 5 results in order, one per cycle.
- Streaming: 16 back-to-back ops with out_ready=1 → 16 results on 16 consecutive cycles, correct order, fifo_count never exceeds 1.
- Reset asserted with 3 ops buffered and out_valid=1 → next cycle out_valid=0 and fifo_count=0; no stale result appears afterwards.
- With ALU_SEQ_ILLEGAL_TRAP_EN: sel=4'b1110 between two legal ops → middle result has out_result=0, out_flags=0, illegal_op=1, out_sel=4'b1110; neighbouring ops are unaffected.
